// File: rtl/system_memory_pkg.sv
// Shared types for the system memory block: the controller state encoding.
package system_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/system_memory_v4_lane_shift_register.sv
// Register of WIDTH bits that can be cleared, parallel-loaded, shifted up by one
// lane with new data entering at the LSBs, or rotated left by one lane.
module lane_shift_register #(
  parameter int WIDTH = 64,
  parameter int LANE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic [LANE-1:0]  shift_in,
  input  logic             rotate_en,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] rotated;

  // A single lane spanning the whole register degenerates to replace / hold.
  generate
    if (LANE == WIDTH) begin : g_full_lane
      assign shifted = shift_in;
      assign rotated = data;
    end else begin : g_part_lane
      assign shifted = {data[WIDTH-LANE-1:0], shift_in};
      assign rotated = {data[WIDTH-LANE-1:0], data[WIDTH-1 -: LANE]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)          data <= '0;
    else if (clear)     data <= '0;
    else if (load_en)   data <= load_data;
    else if (shift_en)  data <= shifted;
    else if (rotate_en) data <= rotated;
  end

endmodule

// File: rtl/system_memory_v4.sv
// Grid state memory: captures generations in run mode, serially loads a new
// grid through a shadow register, and serially dumps the committed grid.
module system_memory_v4
  import system_memory_pkg::*;
#(
  parameter int DATA_SIZE  = 64,
  parameter int LANE_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_SIZE-1:0]  grid_in,
  input  logic                  run_mode,
  input  logic                  load_start,
  input  logic                  output_start,
  input  logic [LANE_WIDTH-1:0] serial_in,
  input  logic                  serial_in_valid,
  output logic [DATA_SIZE-1:0]  system_mem_out,
  output logic [LANE_WIDTH-1:0] serial_out,
  output logic                  serial_out_valid,
  output logic                  busy,
  output logic                  load_done,
  output logic                  output_done
);

  localparam int BEATS = DATA_SIZE / LANE_WIDTH;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  generate
    if (DATA_SIZE % LANE_WIDTH != 0) begin : g_bad_lane
      $error("DATA_SIZE must be a multiple of LANE_WIDTH");
    end
  endgenerate

  mem_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 accept_run, accept_load, accept_dump;
  logic                 load_beat, load_last, dump_last;
  logic [DATA_SIZE-1:0] shadow_q, shadow_next, dump_q, dump_load_data;

  // Commit value includes the beat being accepted on the final load edge.
  generate
    if (LANE_WIDTH == DATA_SIZE) begin : g_full_commit
      assign shadow_next = serial_in;
    end else begin : g_part_commit
      assign shadow_next = {shadow_q[DATA_SIZE-LANE_WIDTH-1:0], serial_in};
    end
  endgenerate

  assign dump_load_data = accept_run ? grid_in : shadow_next;
  assign busy           = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    accept_run  = 1'b0;
    accept_load = 1'b0;
    accept_dump = 1'b0;
    load_beat   = 1'b0;
    load_last   = 1'b0;
    dump_last   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_mode) begin
          accept_run = 1'b1;
        end else if (load_start) begin
          accept_load = 1'b1;
          state_d     = LOAD;
        end else if (output_start) begin
          accept_dump = 1'b1;
          state_d     = DUMP;
        end
      end
      LOAD: begin
        if (serial_in_valid) begin
          load_beat = 1'b1;
          if (cnt_q == LAST_CNT) begin
            load_last = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      DUMP: begin
        if (cnt_q == LAST_CNT) begin
          dump_last = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      system_mem_out   <= '0;
      serial_out       <= '0;
      serial_out_valid <= 1'b0;
      load_done        <= 1'b0;
      output_done      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_load || accept_dump)          cnt_q <= '0;
      else if (load_beat || state_q == DUMP)   cnt_q <= cnt_q + CNT_W'(1);
      if (accept_run)     system_mem_out <= grid_in;
      else if (load_last) system_mem_out <= shadow_next;
      serial_out_valid <= (state_q == DUMP);
      serial_out       <= (state_q == DUMP) ? dump_q[DATA_SIZE-1 -: LANE_WIDTH] : '0;
      load_done        <= load_last;
      output_done      <= dump_last;
    end
  end

  lane_shift_register #(.WIDTH(DATA_SIZE), .LANE(LANE_WIDTH)) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept_load),
    .load_en   (1'b0),
    .load_data ('0),
    .shift_en  (load_beat),
    .shift_in  (serial_in),
    .rotate_en (1'b0),
    .data      (shadow_q)
  );

  // A full rotation restores the pre-dump contents, so dumps are repeatable.
  lane_shift_register #(.WIDTH(DATA_SIZE), .LANE(LANE_WIDTH)) u_dump (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .load_en   (accept_run || load_last),
    .load_data (dump_load_data),
    .shift_en  (1'b0),
    .shift_in  ('0),
    .rotate_en (state_q == DUMP),
    .data      (dump_q)
  );

endmodule

// File: tb/tb_system_memory_v4.sv
// Bench for system_memory_v4: an 8-bit/2-lane instance (a_*) and an 8-bit/1-lane
// instance (b_*) checked against a value-level model of the committed grid.
module tb_system_memory_v4;

  localparam int W  = 8;
  localparam int LA = 2;
  localparam int BA = W / LA;
  localparam int BB = W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [W-1:0]  grid_in;
  logic          run_mode, load_start, output_start;
  logic [LA-1:0] serial_in;
  logic          serial_in_valid;
  logic [W-1:0]  system_mem_out;
  logic [LA-1:0] serial_out;
  logic          serial_out_valid, busy, load_done, output_done;

  logic          b_load_start, b_serial_in, b_serial_in_valid;
  logic [W-1:0]  b_system_mem_out;
  logic          b_serial_out, b_serial_out_valid, b_busy, b_load_done, b_output_done;

  system_memory_v4 #(.DATA_SIZE(W), .LANE_WIDTH(LA)) u_dut_a (
    .clk(clk), .reset(reset), .grid_in(grid_in), .run_mode(run_mode),
    .load_start(load_start), .output_start(output_start),
    .serial_in(serial_in), .serial_in_valid(serial_in_valid),
    .system_mem_out(system_mem_out), .serial_out(serial_out),
    .serial_out_valid(serial_out_valid), .busy(busy),
    .load_done(load_done), .output_done(output_done)
  );

  system_memory_v4 #(.DATA_SIZE(W), .LANE_WIDTH(1)) u_dut_b (
    .clk(clk), .reset(reset), .grid_in(8'h00), .run_mode(1'b0),
    .load_start(b_load_start), .output_start(1'b0),
    .serial_in(b_serial_in), .serial_in_valid(b_serial_in_valid),
    .system_mem_out(b_system_mem_out), .serial_out(b_serial_out),
    .serial_out_valid(b_serial_out_valid), .busy(b_busy),
    .load_done(b_load_done), .output_done(b_output_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: committed grid and dump contents, tracked as whole values.
  logic [W-1:0]  mem_a, dump_a, mem_b;
  logic [LA-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_mem"},   system_mem_out, 0);
    check({tag, "_a_sout"},  serial_out, 0);
    check({tag, "_a_valid"}, serial_out_valid, 0);
    check({tag, "_a_busy"},  busy, 0);
    check({tag, "_a_ldone"}, load_done, 0);
    check({tag, "_a_odone"}, output_done, 0);
    check({tag, "_b_mem"},   b_system_mem_out, 0);
    check({tag, "_b_sout"},  b_serial_out, 0);
    check({tag, "_b_valid"}, b_serial_out_valid, 0);
    check({tag, "_b_busy"},  b_busy, 0);
    check({tag, "_b_ldone"}, b_load_done, 0);
    check({tag, "_b_odone"}, b_output_done, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_a  = '0;
    dump_a = '0;
    mem_b  = '0;
  endtask

  task automatic run_a(input logic [W-1:0] g, input logic with_load);
    grid_in    = g;
    run_mode   = 1'b1;
    load_start = with_load;
    tick();
    run_mode   = 1'b0;
    load_start = 1'b0;
    mem_a  = g;
    dump_a = g;
    check("run_mem", system_mem_out, mem_a);
    check("run_busy", busy, 0);
    tick();
    check("run_stay_idle", busy, 0);
    check("run_mem_hold", system_mem_out, mem_a);
  endtask

  task automatic load_a(input logic [W-1:0] v, input logic with_dump, input int max_gap);
    load_start   = 1'b1;
    output_start = with_dump;
    tick();
    load_start   = 1'b0;
    output_start = 1'b0;
    check("a_load_busy", busy, 1);
    check("a_load_hold", system_mem_out, mem_a);
    for (int i = 0; i < BA; i++) begin
      int gap;
      gap = $urandom_range(max_gap, 0);
      repeat (gap) begin
        serial_in = LA'($urandom);
        tick();
        check("a_gap_hold", system_mem_out, mem_a);
        check("a_gap_done", load_done, 0);
      end
      serial_in_valid = 1'b1;
      serial_in       = v[W-1-LA*i -: LA];
      tick();
      serial_in_valid = 1'b0;
      if (i == BA - 1) begin
        mem_a  = v;
        dump_a = v;
        check("a_load_commit", system_mem_out, v);
        check("a_load_done", load_done, 1);
        check("a_load_idle", busy, 0);
      end else begin
        check("a_beat_hold", system_mem_out, mem_a);
        check("a_beat_done", load_done, 0);
      end
    end
    tick();
    check("a_load_done_pulse", load_done, 0);
  endtask

  task automatic dump_a_run(input logic inject);
    logic [LA-1:0] e;
    output_start = 1'b1;
    tick();
    output_start = 1'b0;
    check("dump_busy", busy, 1);
    check("dump_no_beat", serial_out_valid, 0);
    exp_q.delete();
    for (int i = 0; i < BA; i++) exp_q.push_back(LA'(dump_a >> (W - LA * (i + 1))));
    for (int i = 0; i < BA; i++) begin
      if (inject && i == 1) begin
        run_mode     = 1'b1;
        grid_in      = 8'h11;
        load_start   = 1'b1;
        output_start = 1'b1;
      end
      serial_in_valid = 1'($urandom);
      tick();
      run_mode        = 1'b0;
      load_start      = 1'b0;
      output_start    = 1'b0;
      serial_in_valid = 1'b0;
      e = exp_q.pop_front();
      check("dump_data", serial_out, e);
      check("dump_valid", serial_out_valid, 1);
      check("dump_odone", output_done, (i == BA - 1) ? 1 : 0);
      check("dump_busy_track", busy, (i == BA - 1) ? 0 : 1);
    end
    tick();
    check("dump_end_valid", serial_out_valid, 0);
    check("dump_end_data", serial_out, 0);
    check("dump_end_odone", output_done, 0);
    check("dump_mem_hold", system_mem_out, mem_a);
  endtask

  task automatic load_b(input logic [W-1:0] v, input int gap_after, input int gap_len,
                        input int n_beats);
    b_load_start = 1'b1;
    tick();
    b_load_start = 1'b0;
    check("b_load_busy", b_busy, 1);
    for (int i = 0; i < n_beats; i++) begin
      b_serial_in_valid = 1'b1;
      b_serial_in       = v[W-1-i];
      tick();
      b_serial_in_valid = 1'b0;
      if (i == BB - 1) begin
        mem_b = v;
        check("b_commit", b_system_mem_out, v);
        check("b_load_done", b_load_done, 1);
        check("b_idle", b_busy, 0);
      end else begin
        check("b_beat_hold", b_system_mem_out, mem_b);
        check("b_beat_done", b_load_done, 0);
        check("b_beat_busy", b_busy, 1);
      end
      if (i == gap_after) begin
        repeat (gap_len) begin
          b_serial_in = 1'($urandom);
          tick();
          check("b_gap_hold", b_system_mem_out, mem_b);
          check("b_gap_busy", b_busy, 1);
        end
      end
    end
    if (n_beats == BB) begin
      tick();
      check("b_done_pulse", b_load_done, 0);
    end
  endtask

  initial begin
    reset = 1'b1; grid_in = '0; run_mode = 1'b0; load_start = 1'b0;
    output_start = 1'b0; serial_in = '0; serial_in_valid = 1'b0;
    b_load_start = 1'b0; b_serial_in = 1'b0; b_serial_in_valid = 1'b0;
    mem_a = '0; dump_a = '0; mem_b = '0;
    repeat (2) tick();
    reset = 1'b0;
    check_all_zero("por");

    // Serial load 1,0,1,0,0,1,0,1 with two idle cycles after the third beat.
    load_b(8'hA5, 2, 2, BB);

    // 0xA5 dumped twice over two-bit lanes: 2,2,1,1 both times.
    load_a(8'hA5, 1'b0, 0);
    dump_a_run(1'b0);
    dump_a_run(1'b0);

    // run_mode beats load_start in the same cycle.
    run_a(8'h3C, 1'b1);

    // Commands arriving mid-dump are ignored.
    dump_a_run(1'b1);

    // Reset aborts a partial load on b and a running dump on a.
    load_b(8'hFF, -1, 0, 3);
    output_start = 1'b1;
    tick();
    output_start = 1'b0;
    repeat (2) tick();
    do_reset();
    check_all_zero("abort");
    load_b(8'hFF, -1, 0, BB);
    dump_a_run(1'b0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(2, 0))
        0:       run_a(W'($urandom), 1'($urandom));
        1:       load_a(W'($urandom), 1'($urandom), 2);
        default: dump_a_run(1'($urandom));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/system_memory_v4.md
SYSTEM_MEMORY_V4 -- requirements
Module: system_memory_v4

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 64, meaning the grid state width in bits.
REQ-002 The block SHALL have parameter LANE_WIDTH, default 1, meaning bits per serial beat; DATA_SIZE % LANE_WIDTH == 0 is enforced by elaboration assertion.
REQ-003 The block SHALL have derived constant BEATS = DATA_SIZE / LANE_WIDTH; counter width is $clog2(BEATS+1).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  system clock, rising edge only.
REQ-005 The block SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port grid_in  input  DATA_SIZE  next generation from the grid calculator.
REQ-007 The block SHALL have port run_mode  input  1  capture grid_in (level).
REQ-008 The block SHALL have port load_start  input  1  begin serial load (single-cycle strobe).
REQ-009 The block SHALL have port output_start  input  1  begin serial dump (single-cycle strobe).
REQ-010 The block SHALL have port serial_in  input  LANE_WIDTH  load data lane.
REQ-011 The block SHALL have port serial_in_valid  input  1  serial_in beat is valid this cycle.
REQ-012 The block SHALL have port system_mem_out  output  DATA_SIZE  committed grid state.
REQ-013 The block SHALL have port serial_out  output  LANE_WIDTH  dump data lane.
REQ-014 The block SHALL have port serial_out_valid  output  1  serial_out beat is valid.
REQ-015 The block SHALL have ports busy  output  1  (state != IDLE), load_done  output  1  (1-cycle pulse) and output_done  output  1  (1-cycle pulse).

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and DUMP; all outputs are registered except busy, which is decoded from state.
REQ-017 In IDLE the command priority SHALL be run_mode > load_start > output_start; the lower-priority commands in the same cycle are dropped.
REQ-018 When run_mode is set in IDLE, both system_mem_out and the dump register SHALL take grid_in at that edge; the state stays IDLE (1-cycle latency).
REQ-019 load_start in IDLE SHALL clear the beat counter, clear the load shadow register and enter LOAD.
REQ-020 In LOAD, each serial_in_valid beat SHALL shift the shadow register up by LANE_WIDTH, insert serial_in at the LSBs and increment the counter; cycles with no valid beat hold the register and counter.
REQ-021 system_mem_out SHALL NOT change during LOAD.
REQ-022 On the edge accepting beat BEATS, the block SHALL write the full shadow value (this beat included) to system_mem_out and to the dump register, pulse load_done and return to IDLE.
REQ-023 output_start in IDLE SHALL enter DUMP with the counter cleared.
REQ-024 At each edge in DUMP, the block SHALL drive serial_out with the top LANE_WIDTH bits of the dump register, set serial_out_valid, rotate the register left by LANE_WIDTH and increment the counter; data is MSB-lane first.
REQ-025 On the edge emitting beat BEATS, the block SHALL pulse output_done and return to IDLE; the rotation leaves the dump register equal to its pre-dump value, so repeated dumps are identical.
REQ-026 The block SHALL clear serial_out_valid (serial_out to 0) on every edge that emits no beat.
REQ-027 The block SHALL ignore run_mode, load_start and output_start while busy; it SHALL ignore serial_in_valid outside LOAD.
REQ-028 Timing: output_start at edge t SHALL give the first beat at edge t+1 and the last beat plus output_done at edge t+BEATS.

Reset
REQ-029 When reset is high at a clock edge, the block SHALL set state to IDLE and clear the counter, shadow register, dump register, system_mem_out, serial_out, serial_out_valid, load_done and output_done; reset overrides every other input.
REQ-030 Reset during LOAD or DUMP SHALL abort the operation; a partial load SHALL never reach system_mem_out.

Structure
REQ-031 The shared package system_memory_pkg SHALL hold the state enum mem_state_t.
REQ-032 The block SHALL use one sub-module, lane_shift_register (parameters WIDTH and LANE; ports for parallel load, lane shift-in, and rotate), instantiated twice: once as the load shadow and once as the dump register.

Verification (DATA_SIZE=8 unless stated)
REQ-033 Load with LANE_WIDTH=1, beats 1,0,1,0,0,1,0,1 (valid low for 2 cycles after beat 3) -> system_mem_out stays 0x00 until the 8th beat, then 0xA5 with a 1-cycle load_done pulse.
REQ-034 With LANE_WIDTH=2 and 0xA5 loaded, output_start -> serial_out = 2,2,1,1 on 4 consecutive valid cycles, output_done with beat 4; a second dump gives the same sequence.
REQ-035 run_mode and load_start high together in IDLE with grid_in=0x3C -> system_mem_out=0x3C next cycle, state remains IDLE, no LOAD entered.
REQ-036 Reset asserted after 3 load beats -> all outputs 0 and state IDLE; a following load of 0xFF needs all 8 beats before it commits.
REQ-037 Commands during DUMP (run_mode with grid_in=0x11, load_start) -> ignored; the dump completes unchanged and system_mem_out is unchanged.
